// File: rtl/divu_controller.sv
// Control FSM for the iterative restoring divider: one quotient bit per SHIFT+COMPARE pair.
// Optional divide-by-zero short-circuit: define DIVU_DIVZERO_CHECK_EN.
module divu_controller #(
    parameter int         ITER_COUNT = 10,
    // Counter preload so that the terminal flag (count==15) marks the last iteration.
    parameter logic [3:0] CNT_INIT   = 4'(16 - ITER_COUNT)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       lt,
    input  logic       carryO,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       ld_dividend,
    output logic       ld_divisor,
    output logic       rem_clr,
    output logic       shift_en,
    output logic       ld_rem,
    output logic       sel_sub,
    output logic       ld_quot,
    output logic       q_bit,
    output logic       cnt_load,
    output logic [3:0] cnt_init,
    output logic       cnt_en
`ifdef DIVU_DIVZERO_CHECK_EN
    ,
    input  logic       divisor_zero,
    output logic       dz_error
`endif
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_COMPARE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
`ifdef DIVU_DIVZERO_CHECK_EN
    // Distinct DONE flavour so dz_error stays a pure state decode.
    localparam logic [2:0] ST_DZ_DONE = 3'd5;
`endif

    logic [2:0] state;
    logic [2:0] state_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first, so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
`ifdef DIVU_DIVZERO_CHECK_EN
                    state_next = divisor_zero ? ST_DZ_DONE : ST_LOAD;
`else
                    state_next = ST_LOAD;
`endif
                end
            end
            ST_LOAD:    state_next = ST_SHIFT;
            ST_SHIFT:   state_next = ST_COMPARE;
            ST_COMPARE: state_next = carryO ? ST_DONE : ST_SHIFT;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        ld_dividend = 1'b0;
        ld_divisor  = 1'b0;
        rem_clr     = 1'b0;
        shift_en    = 1'b0;
        ld_rem      = 1'b0;
        sel_sub     = 1'b0;
        ld_quot     = 1'b0;
        q_bit       = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
`ifdef DIVU_DIVZERO_CHECK_EN
        dz_error    = 1'b0;
`endif
        case (state)
            ST_IDLE: ready = 1'b1;
            ST_LOAD: begin
                busy        = 1'b1;
                ld_dividend = 1'b1;
                ld_divisor  = 1'b1;
                rem_clr     = 1'b1;
                cnt_load    = 1'b1;
            end
            ST_SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
            end
            ST_COMPARE: begin
                // Restore-or-subtract decision is Mealy on the comparator flag.
                busy    = 1'b1;
                q_bit   = ~lt;
                ld_rem  = ~lt;
                sel_sub = ~lt;
                ld_quot = 1'b1;
                cnt_en  = 1'b1;
            end
            ST_DONE: done = 1'b1;
`ifdef DIVU_DIVZERO_CHECK_EN
            ST_DZ_DONE: begin
                done     = 1'b1;
                dz_error = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign cnt_init = CNT_INIT;

endmodule
